// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for gray_counter and the blocks around it.
// bin2gray works on the widest supported code.
// Callers cast the operand up to GRAY_MAX_W bits and cast the result back
// down to their own width.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;
    localparam int GRAY_MIN_W = 2;

    // Convert a binary value to its reflected Gray code.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Legal code widths are GRAY_MIN_W..GRAY_MAX_W bits.
    function automatic bit width_ok(input int w);
        return (w >= GRAY_MIN_W) && (w <= GRAY_MAX_W);
    endfunction

endpackage

// File: rtl/gray_counter.sv
// Up/down counter that exposes its count as a registered Gray code.
// Exactly one gray bit changes per count step, so the code can cross clock domains.
// A binary count register is kept alongside the Gray register.
// The Gray register is loaded from the next binary value, so gray_out never
// lags cnt_q and has no combinational path from any input.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             wrap_pulse
);

    // Refuse to elaborate with a code width the helpers cannot represent.
    if (!width_ok(WIDTH)) begin : g_width_check
        $error("gray_counter: WIDTH must be between 2 and 32");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    // Terminal count depends on direction: all-ones when counting up, zero when counting down.
    always_comb begin
        tc = up ? (cnt_q == {WIDTH{1'b1}}) : (cnt_q == '0);
    end

    // Next-state selection: load wins over counting.
    // At terminal count the counter either wraps or saturates, depending on WRAP.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = load_bin;
        end else if (en) begin
            if (!tc) begin
                cnt_d = up ? cnt_q + 1'b1 : cnt_q - 1'b1;
            end else if (WRAP != 0) begin
                cnt_d  = up ? '0 : {WIDTH{1'b1}};
                wrap_d = 1'b1;
            end
        end
        gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(cnt_d)));
    end

    // State registers.
    // Reset is synchronous and overrides any load or count on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign gray_out   = gray_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter.
// A wrapping (WRAP=1) instance and a saturating (WRAP=0) instance share the same stimulus.
// Each instance is checked against an integer reference model of the count.
// The gray output is also decoded back to binary, as a downstream decoder
// would do, and that binary value is compared with the model.
module tb_gray_counter;
    import gray_pkg::*;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] loadBin = '0;

    logic [W-1:0] grayW, grayS;
    logic         tcW, tcS, wrapW, wrapS;

    int total = 0;
    int bad   = 0;

    // Reference model state; index 0 = wrapping instance, index 1 = saturating instance.
    int modelCnt [2];
    int modelWrap [2];

    logic [W-1:0] prevGray [2];

    gray_counter #(.WIDTH(W), .WRAP(1)) dutWrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(loadBin),
        .gray_out(grayW), .tc(tcW), .wrap_pulse(wrapW)
    );

    gray_counter #(.WIDTH(W), .WRAP(0)) dutSat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(loadBin),
        .gray_out(grayS), .tc(tcS), .wrap_pulse(wrapS)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: run still active at time %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Decode Gray to binary the way a downstream decoder does:
    // each binary bit is the XOR of all gray bits at or above it.
    function automatic int grayToBin(input logic [W-1:0] g);
        int r = 0;
        for (int i = 0; i < W; i++) begin
            r[i] = ^(g >> i);
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the reference model by one clock edge, using the inputs presented to that edge.
    task automatic updateModel();
        for (int k = 0; k < 2; k++) begin
            bit doesWrap = (k == 0);
            modelWrap[k] = 0;
            if (rst) begin
                modelCnt[k] = 0;
            end else if (load) begin
                modelCnt[k] = int'(loadBin);
            end else if (en) begin
                if (up && modelCnt[k] == MAX) begin
                    if (doesWrap) begin modelCnt[k] = 0; modelWrap[k] = 1; end
                end else if (!up && modelCnt[k] == 0) begin
                    if (doesWrap) begin modelCnt[k] = MAX; modelWrap[k] = 1; end
                end else begin
                    modelCnt[k] = up ? modelCnt[k] + 1 : modelCnt[k] - 1;
                end
            end
        end
    endtask

    // Compare both instances against the model.
    // On a plain step (no load, no reset), also check the single-bit-change property.
    task automatic checkAll(input string tag, input bit plainStep, input int oldCnt0, input int oldCnt1);
        logic [W-1:0] g [2];
        int oldCnt [2];
        logic [3:0] tcs, wraps;
        g[0] = grayW;  g[1] = grayS;
        tcs = {2'b00, tcS, tcW};
        wraps = {2'b00, wrapS, wrapW};
        oldCnt[0] = oldCnt0;
        oldCnt[1] = oldCnt1;
        for (int k = 0; k < 2; k++) begin
            int expTc = up ? int'(modelCnt[k] == MAX) : int'(modelCnt[k] == 0);
            checkOutput({tag, k == 0 ? ":gray.w" : ":gray.s"}, 32'(g[k]),
                        32'(W'(bin2gray(GRAY_MAX_W'(modelCnt[k])))));
            checkOutput({tag, k == 0 ? ":bin.w" : ":bin.s"}, grayToBin(g[k]), modelCnt[k]);
            checkOutput({tag, k == 0 ? ":tc.w" : ":tc.s"}, 32'(tcs[k]), expTc);
            checkOutput({tag, k == 0 ? ":wrap.w" : ":wrap.s"}, 32'(wraps[k]), modelWrap[k]);
            if (plainStep) begin
                checkOutput({tag, k == 0 ? ":hamming.w" : ":hamming.s"},
                            $countones(g[k] ^ prevGray[k]),
                            (modelCnt[k] != oldCnt[k]) ? 1 : 0);
            end
        end
        prevGray[0] = grayW;
        prevGray[1] = grayS;
    endtask

    // Present one set of inputs away from the active edge.
    // Then take the edge, update the model and check shortly after the edge.
    task automatic applyStimulus(input string tag, input bit r, input bit e, input bit u,
                                 input bit l, input logic [W-1:0] lb);
        int old0, old1;
        @(negedge clk);
        rst = r; en = e; up = u; load = l; loadBin = lb;
        old0 = modelCnt[0];
        old1 = modelCnt[1];
        @(posedge clk);
        updateModel();
        #1;
        checkAll(tag, !r && !l, old0, old1);
    endtask

    initial begin
        int seq [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
        modelCnt[0] = 0;  modelCnt[1] = 0;
        modelWrap[0] = 0; modelWrap[1] = 0;
        prevGray[0] = '0; prevGray[1] = '0;

        // Reset state, seen with both counting directions.
        applyStimulus("reset", 1, 0, 1, 0, '0);
        checkOutput("reset:tc_up", 32'(tcW), 0);
        applyStimulus("reset", 1, 0, 0, 0, '0);
        checkOutput("reset:tc_down", 32'(tcW), 1);

        // Count up through a full cycle and compare against the known Gray sequence.
        applyStimulus("up_idle", 0, 0, 1, 0, '0);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus("up_seq", 0, 1, 1, 0, '0);
            checkOutput("up_seq:const", 32'(grayW), seq[i]);
        end
        checkOutput("up_seq:wrap_on_return", 32'(wrapW), 1);

        // Down step from zero: the wrapping instance goes to 15, the saturating one holds.
        applyStimulus("rst2", 1, 0, 0, 0, '0);
        applyStimulus("down_wrap", 0, 1, 0, 0, '0);
        checkOutput("down_wrap:gray", 32'(grayW), 8);
        checkOutput("down_wrap:pulse", 32'(wrapW), 1);
        applyStimulus("down_wrap_idle", 0, 0, 0, 0, '0);
        checkOutput("down_wrap:pulse_once", 32'(wrapW), 0);

        // Saturating instance held at 0 while counting down, then held at 15 while counting up.
        applyStimulus("rst3", 1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("sat_low", 0, 1, 0, 0, '0);
            checkOutput("sat_low:gray", 32'(grayS), 0);
            checkOutput("sat_low:tc", 32'(tcS), 1);
        end
        applyStimulus("sat_load15", 0, 0, 1, 1, 4'hF);
        applyStimulus("sat_high", 0, 1, 1, 0, '0);
        checkOutput("sat_high:gray", 32'(grayS), 8);

        // Load wins over a simultaneous count enable.
        applyStimulus("load_en", 0, 1, 1, 1, 4'b1010);
        checkOutput("load_en:gray", 32'(grayW), 4'b1111);
        checkOutput("load_en:bin", grayToBin(grayW), 4'b1010);

        // Reset during a count aborts it; counting then resumes from zero.
        applyStimulus("rst5", 1, 0, 1, 0, '0);
        for (int i = 0; i < 5; i++) applyStimulus("to5", 0, 1, 1, 0, '0);
        checkOutput("to5:gray", 32'(grayW), 4'b0111);
        applyStimulus("rst_mid", 1, 1, 1, 0, '0);
        checkOutput("rst_mid:gray", 32'(grayW), 0);
        applyStimulus("resume", 0, 1, 1, 0, '0);
        checkOutput("resume:gray", 32'(grayW), 1);

        // Random enable, direction, load and occasional reset.
        for (int i = 0; i < 10000; i++) begin
            bit r = ($urandom_range(199) == 0);
            bit e = ($urandom_range(3) != 0);
            bit u = $urandom_range(1) != 0;
            bit l = ($urandom_range(15) == 0);
            logic [W-1:0] lb = W'($urandom);
            applyStimulus("rnd", r, e, u, l, lb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
